ddr2_app_arbiter: RTL and testbench

// Shares the single MIG (Virtex-5 DDR2) user command/write-data port between a write-stream client
// and a read-stream client. Sequences fixed-length command bursts per grant.
// - Write bursts: data is popped from the write client, then each command is issued.
// - Read bursts: issue is throttled by an outstanding-read credit counter.

---
 rtl/ddr2_arb_pkg.sv | 15 +
 rtl/ddr2_rd_credit_counter.sv | 39 +++
 rtl/ddr2_app_arbiter.sv | 144 ++++++++++++++
 tb/tb_ddr2_app_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_arb_pkg.sv
// Shared encodings for the DDR2 MIG app-port arbiter.
// Command codes follow the MIG app_af_cmd field.
package ddr2_arb_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        WR_D0,
        WR_D1,
        RD_CMD
    } arb_state_t;

endpackage

// File: rtl/ddr2_rd_credit_counter.sv
// Outstanding-read credit tracker for the MIG read path.
// Two data beats retire one read command.
module ddr2_rd_credit_counter (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       rd_data_valid,
    output logic [7:0] count,
    output logic       ovf_err
);

    logic half;
    logic dec;

    assign dec = rd_data_valid && (count != 8'd0) && half;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            count   <= 8'd0;
            half    <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            // a beat with nothing in flight is dropped, not counted
            if (rd_data_valid) begin
                if (count == 8'd0) begin
                    ovf_err <= 1'b1;
                end else begin
                    half <= !half;
                end
            end
            if (inc && !dec) begin
                count <= count + 8'd1;
            end else if (dec && !inc) begin
                count <= count - 8'd1;
            end
        end
    end

endmodule

// File: rtl/ddr2_app_arbiter.sv
// Round-robin sharing of the MIG command/write-data port between
// a write-stream client and a read-stream client.
module ddr2_app_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 31,
    parameter int unsigned APP_DW     = 64,
    parameter int unsigned BURST_CMDS = 8,
    parameter int unsigned CMD_WORDS  = 2,
    parameter int unsigned ADDR_INC   = 4,
    parameter int unsigned MAX_RD_OUT = 16
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                phy_init_done,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic                wr_gnt,
    output logic                wr_data_rd,
    input  logic [APP_DW-1:0]   wr_data,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_gnt,
    output logic [2:0]          app_af_cmd,
    output logic [ADDR_W-1:0]   app_af_addr,
    output logic                app_af_wren,
    input  logic                app_af_afull,
    output logic                app_wdf_wren,
    output logic [APP_DW-1:0]   app_wdf_data,
    output logic [APP_DW/8-1:0] app_wdf_mask_data,
    input  logic                app_wdf_afull,
    input  logic                rd_data_valid,
    output logic                busy,
    output logic [7:0]          rd_outstanding,
    output logic                ovf_err
);

    if (CMD_WORDS != 2) begin : g_bad_words
        $error("ddr2_app_arbiter supports two wdf words per command only");
    end

    arb_state_t        state;
    logic              last_rd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        cmd_cnt;

    logic       rd_ok;
    logic       pick_wr;
    logic       pick_rd;
    logic       d0_go;
    logic       d1_go;
    logic       rd_go;
    logic       last_cmd;
    logic [8:0] rd_sum;

    assign rd_sum   = {1'b0, rd_outstanding} + 9'(BURST_CMDS);
    assign rd_ok    = rd_req && (rd_sum <= 9'(MAX_RD_OUT));
    assign pick_wr  = phy_init_done && wr_req && (!rd_ok || last_rd);
    assign pick_rd  = phy_init_done && rd_ok && (!wr_req || !last_rd);
    assign d0_go    = (state == WR_D0) && !app_wdf_afull;
    assign d1_go    = (state == WR_D1) && !app_wdf_afull && !app_af_afull;
    assign rd_go    = (state == RD_CMD) && !app_af_afull;
    assign last_cmd = (cmd_cnt == 8'd1);

    // strobes follow the almost-full flags in the same cycle
    assign wr_data_rd        = d0_go || d1_go;
    assign app_wdf_wren      = d0_go || d1_go;
    assign app_af_wren       = d1_go || rd_go;
    assign app_af_addr       = addr;
    assign app_wdf_data      = wr_data;
    assign app_wdf_mask_data = '0;
    assign busy              = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_rd    <= 1'b1;
            addr       <= '0;
            cmd_cnt    <= 8'd0;
            app_af_cmd <= CMD_WR;
            wr_gnt     <= 1'b0;
            rd_gnt     <= 1'b0;
        end else begin
            wr_gnt <= 1'b0;
            rd_gnt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_wr) begin
                        wr_gnt     <= 1'b1;
                        addr       <= wr_addr;
                        cmd_cnt    <= 8'(BURST_CMDS);
                        last_rd    <= 1'b0;
                        app_af_cmd <= CMD_WR;
                        state      <= WR_D0;
                    end else if (pick_rd) begin
                        rd_gnt     <= 1'b1;
                        addr       <= rd_addr;
                        cmd_cnt    <= 8'(BURST_CMDS);
                        last_rd    <= 1'b1;
                        app_af_cmd <= CMD_RD;
                        state      <= RD_CMD;
                    end
                end
                WR_D0: begin
                    if (d0_go) begin
                        state <= WR_D1;
                    end
                end
                WR_D1: begin
                    if (d1_go) begin
                        cmd_cnt <= cmd_cnt - 8'd1;
                        // keep the last command address visible once idle
                        if (last_cmd) begin
                            state <= IDLE;
                        end else begin
                            addr  <= addr + ADDR_W'(ADDR_INC);
                            state <= WR_D0;
                        end
                    end
                end
                RD_CMD: begin
                    if (rd_go) begin
                        cmd_cnt <= cmd_cnt - 8'd1;
                        if (last_cmd) begin
                            state <= IDLE;
                        end else begin
                            addr <= addr + ADDR_W'(ADDR_INC);
                        end
                    end
                end
            endcase
        end
    end

    ddr2_rd_credit_counter u_credit (
        .clk_in        (clk_in),
        .reset_n       (reset_n),
        .inc           (rd_go),
        .rd_data_valid (rd_data_valid),
        .count         (rd_outstanding),
        .ovf_err       (ovf_err)
    );

endmodule

// File: tb/tb_ddr2_app_arbiter.sv
// Scoreboard bench for ddr2_app_arbiter: randomized bursts against a
// queue-based model of grants, commands, write data and read credits.
module tb_ddr2_app_arbiter;
    import ddr2_arb_pkg::*;

    localparam int AW   = 31;
    localparam int DW   = 64;
    localparam int BC   = 8;
    localparam int INC  = 4;

    logic          clk_in = 1'b0;
    logic          reset_n = 1'b0;
    logic          phy_init_done = 1'b0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          app_af_afull = 1'b0;
    logic          app_wdf_afull = 1'b0;
    logic          rd_data_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;

    logic          wr_gnt, rd_gnt, wr_data_rd;
    logic [2:0]    app_af_cmd;
    logic [AW-1:0] app_af_addr;
    logic          app_af_wren, app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask_data;
    logic          busy, ovf_err;
    logic [7:0]    rd_outstanding;

    ddr2_app_arbiter dut (
        .clk_in(clk_in), .reset_n(reset_n), .phy_init_done(phy_init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt),
        .wr_data_rd(wr_data_rd), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .app_af_cmd(app_af_cmd), .app_af_addr(app_af_addr),
        .app_af_wren(app_af_wren), .app_af_afull(app_af_afull),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
        .app_wdf_mask_data(app_wdf_mask_data), .app_wdf_afull(app_wdf_afull),
        .rd_data_valid(rd_data_valid), .busy(busy),
        .rd_outstanding(rd_outstanding), .ovf_err(ovf_err)
    );

    always #5 clk_in = ~clk_in;

    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_wdf[$];
    logic [33:0]   exp_cmd[$];
    bit            exp_gnt[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_afull = 0;
    bit last_rd = 1;
    int m_cnt = 0;
    bit m_half = 0;
    bit m_ovf = 0;
    int words = 0;
    int wcmds = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic report(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not matched by model at %0t", nm, $time);
    endtask

    // first-word-fall-through write client
    always @(posedge clk_in) begin
        if (wr_data_rd && wq.size() > 0) begin
            void'(wq.pop_front());
            wr_data = (wq.size() > 0) ? wq[0] : '0;
        end
    end

    logic [33:0] mc;
    bit          minc;
    bit          mk;

    always @(negedge clk_in) begin : mon
        if (!reset_n) begin
            m_cnt = 0; m_half = 0; m_ovf = 0; words = 0; wcmds = 0;
        end else begin
            minc = 0;
            if (wr_gnt || rd_gnt) begin
                if (exp_gnt.size() == 0) report("gnt_unexpected");
                else begin
                    mk = exp_gnt.pop_front();
                    check("gnt_kind", 64'({wr_gnt, rd_gnt}), 64'({!mk, mk}));
                end
            end
            if (app_wdf_wren || wr_data_rd)
                check("wdf_pop_pair", 64'({wr_data_rd, app_wdf_wren}), 64'(2'b11));
            if (app_wdf_wren) begin
                words++;
                check("wdf_mask", 64'(app_wdf_mask_data), 64'(0));
                if (exp_wdf.size() == 0) report("wdf_unexpected");
                else check("wdf_data", app_wdf_data, exp_wdf.pop_front());
            end
            if (app_af_wren) begin
                if (exp_cmd.size() == 0) report("cmd_unexpected");
                else begin
                    mc = exp_cmd.pop_front();
                    check("cmd", 64'({app_af_cmd, app_af_addr}), 64'(mc));
                end
                if (app_af_cmd == CMD_WR) begin
                    wcmds++;
                    check("cmd_with_word2", 64'({app_wdf_wren, words}),
                          64'({1'b1, 2 * wcmds}));
                end else begin
                    minc = 1;
                end
            end
            check("rd_outstanding", 64'(rd_outstanding), 64'(m_cnt));
            check("ovf_err", 64'(ovf_err), 64'(m_ovf));
            // one command retires per two beats; a beat with none in flight is an error
            if (rd_data_valid) begin
                if (m_cnt == 0) m_ovf = 1;
                else if (m_half) begin m_half = 0; m_cnt--; end
                else m_half = 1;
            end
            if (minc) m_cnt++;
        end
    end

    task automatic cycle();
        @(posedge clk_in);
        #2;
        if (rand_afull) begin
            app_af_afull  = ($urandom % 4) == 0;
            app_wdf_afull = ($urandom % 4) == 0;
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        exp_gnt.push_back(1'b0);
        for (int i = 0; i < 2 * BC; i++) begin
            w = {$urandom, $urandom};
            wq.push_back(w);
            exp_wdf.push_back(w);
        end
        for (int i = 0; i < BC; i++)
            exp_cmd.push_back({CMD_WR, a + AW'(i * INC)});
        wr_data = wq[0];
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        exp_gnt.push_back(1'b1);
        for (int i = 0; i < BC; i++)
            exp_cmd.push_back({CMD_RD, a + AW'(i * INC)});
    endtask

    task automatic wait_gnt(input int lim);
        int n = 0;
        do begin
            cycle();
            n++;
            if (n > lim) begin report("gnt_timeout"); return; end
        end while (!(wr_gnt || rd_gnt));
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (exp_cmd.size() > 0 || exp_wdf.size() > 0 || busy) begin
            cycle();
            n++;
            if (n > lim) begin report("idle_timeout"); return; end
        end
    endtask

    task automatic do_wr(input logic [AW-1:0] a);
        push_wr(a);
        wr_addr = a;
        wr_req = 1;
        wait_gnt(60);
        wr_req = 0;
        last_rd = 0;
        wait_idle(500);
    endtask

    task automatic do_rd(input logic [AW-1:0] a);
        push_rd(a);
        rd_addr = a;
        rd_req = 1;
        wait_gnt(60);
        rd_req = 0;
        last_rd = 1;
        wait_idle(500);
    endtask

    task automatic do_both(input logic [AW-1:0] a, input logic [AW-1:0] b);
        if (last_rd) begin push_wr(a); push_rd(b); end
        else begin push_rd(b); push_wr(a); end
        wr_addr = a;
        rd_addr = b;
        wr_req = 1;
        rd_req = 1;
        wait_gnt(60);
        if (wr_gnt) wr_req = 0;
        else rd_req = 0;
        wait_gnt(500);
        wr_req = 0;
        rd_req = 0;
        wait_idle(500);
    endtask

    task automatic beats(input int n);
        int k = 0;
        while (k < n) begin
            rd_data_valid = $urandom_range(0, 1);
            if (rd_data_valid) k++;
            cycle();
        end
        rd_data_valid = 0;
    endtask

    task automatic clear_model();
        wq.delete();
        exp_wdf.delete();
        exp_cmd.delete();
        exp_gnt.delete();
        wr_data = '0;
        last_rd = 1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        wr_req = 0;
        rd_req = 0;
        rd_data_valid = 0;
        app_af_afull = 0;
        app_wdf_afull = 0;
        repeat (2) cycle();
        clear_model();
        reset_n = 1;
        cycle();
    endtask

    int cnt;
    int kind;
    logic [AW-1:0] ra, rb;

    initial begin
        repeat (3) cycle();
        check("reset_outputs", 64'({wr_gnt, rd_gnt, wr_data_rd, app_af_wren,
              app_wdf_wren, busy, ovf_err, app_af_cmd, rd_outstanding}), 64'(0));
        check("reset_addr", 64'(app_af_addr), 64'(0));
        reset_n = 1;
        cycle();

        wr_req = 1;
        rd_req = 1;
        cnt = 0;
        repeat (100) begin
            cycle();
            if (wr_gnt | rd_gnt | app_af_wren | app_wdf_wren | wr_data_rd) cnt++;
        end
        check("no_activity_before_init", 64'(cnt), 64'(0));
        wr_req = 0;
        rd_req = 0;
        phy_init_done = 1;
        cycle();

        do_wr(31'h100);
        check("single_wr_cmds", 64'(wcmds), 64'(8));
        check("single_wr_words", 64'(words), 64'(16));

        do_reset();
        push_wr(31'h400); push_rd(31'h800); push_wr(31'h400); push_rd(31'h800);
        wr_addr = 31'h400;
        rd_addr = 31'h800;
        wr_req = 1;
        rd_req = 1;
        repeat (4) wait_gnt(100);
        wr_req = 0;
        rd_req = 0;
        wait_idle(600);
        last_rd = 1;
        check("rr_credits", 64'(rd_outstanding), 64'(16));
        beats(32);
        cycle();
        check("rr_drained", 64'(rd_outstanding), 64'(0));

        do_reset();
        push_rd(31'hA00); push_rd(31'hA00);
        rd_addr = 31'hA00;
        rd_req = 1;
        repeat (2) wait_gnt(100);
        cnt = 0;
        repeat (40) begin cycle(); if (rd_gnt | wr_gnt) cnt++; end
        check("credit_block", 64'(cnt), 64'(0));
        check("credit_full", 64'(rd_outstanding), 64'(16));
        rd_req = 0;
        last_rd = 1;
        beats(32);
        cycle();
        check("credit_empty", 64'(rd_outstanding), 64'(0));
        do_rd(31'hB00);
        check("credit_regrant", 64'(rd_outstanding), 64'(8));
        beats(16);

        do_reset();
        push_wr(31'h2000);
        wr_addr = 31'h2000;
        wr_req = 1;
        wait_gnt(60);
        wr_req = 0;
        last_rd = 0;
        repeat (3) cycle();
        app_wdf_afull = 1;
        cnt = 0;
        repeat (5) begin cycle(); if (app_wdf_wren | wr_data_rd | app_af_wren) cnt++; end
        check("wdf_afull_stall", 64'(cnt), 64'(0));
        app_wdf_afull = 0;
        repeat (2) cycle();
        app_af_afull = 1;
        cnt = 0;
        repeat (5) begin cycle(); if (app_af_wren) cnt++; end
        check("af_afull_stall_wr", 64'(cnt), 64'(0));
        app_af_afull = 0;
        wait_idle(500);
        check("stall_wr_cmds", 64'(wcmds), 64'(8));
        check("stall_wr_words", 64'(words), 64'(16));
        push_rd(31'h3000);
        rd_addr = 31'h3000;
        rd_req = 1;
        wait_gnt(60);
        rd_req = 0;
        last_rd = 1;
        repeat (2) cycle();
        app_af_afull = 1;
        cnt = 0;
        repeat (5) begin cycle(); if (app_af_wren) cnt++; end
        check("af_afull_stall_rd", 64'(cnt), 64'(0));
        app_af_afull = 0;
        wait_idle(500);
        beats(16);

        do_wr(31'h7FFFFFFC);

        rand_afull = 1;
        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 2);
            ra = AW'($urandom);
            rb = AW'($urandom);
            if (i == 0) ra = 31'h7FFFFFF0;
            case (kind)
                0: do_wr(ra);
                1: begin do_rd(rb); beats(16); end
                default: begin do_both(ra, rb); beats(16); end
            endcase
        end
        rand_afull = 0;
        app_af_afull = 0;
        app_wdf_afull = 0;
        cycle();
        check("sb_empty", 64'(exp_cmd.size() + exp_wdf.size() + exp_gnt.size()), 64'(0));

        do_rd(31'h500);
        push_wr(31'h600);
        wr_addr = 31'h600;
        wr_req = 1;
        wait_gnt(60);
        wr_req = 0;
        repeat (4) cycle();
        reset_n = 0;
        cycle();
        check("midburst_reset", 64'({wr_gnt, rd_gnt, wr_data_rd, app_af_wren,
              app_wdf_wren, busy, ovf_err, app_af_cmd, rd_outstanding}), 64'(0));
        check("midburst_reset_addr", 64'(app_af_addr), 64'(0));
        clear_model();
        reset_n = 1;
        cycle();
        rd_data_valid = 1;
        cycle();
        rd_data_valid = 0;
        cycle();
        check("ovf_set", 64'(ovf_err), 64'(1));
        check("ovf_no_dec", 64'(rd_outstanding), 64'(0));
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
